// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_stall_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } state_e;

  localparam int CNT_W  = 32;
  localparam int WDOG_W = 8;
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(255);

  // Stage control bundle driven by the controller each cycle.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idexe_en;
    logic exemem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idexe_flush;
    logic exemem_flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam stage_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam stage_ctrl_t CTRL_MDU    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam stage_ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam stage_ctrl_t CTRL_LDUSE  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: step by one on inc, pinned at all-ones.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: memory freeze, multi-cycle unit wait,
// branch redirect and load-use bubbles, plus stall/flush statistics and a
// memory-wait watchdog.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             im_stall,
  input  logic             dm_stall,
  input  logic             load_use,
  input  logic             branch_redirect,
  input  logic             mdu_start,
  input  logic             mdu_done,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idexe_en,
  output logic             exemem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idexe_flush,
  output logic             exemem_flush,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             timeout_err
);

  state_e              state_q, state_d;
  logic                done_pend_q, done_pend_d;
  logic [WDOG_W-1:0]   wait_q, wait_d;
  logic                timeout_q, timeout_d;
  stage_ctrl_t         ctrl;
  logic                freeze;
  logic                redirect;

  assign freeze = im_stall | dm_stall;

  // Next state and stage controls; freeze outranks everything, then the
  // multi-cycle unit, then redirect, then load-use.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // one unassigned, which would infer a latch.
    state_d     = state_q;
    done_pend_d = done_pend_q;
    ctrl        = CTRL_RUN;
    redirect    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (freeze) begin
          ctrl = CTRL_FREEZE;
        end else if (mdu_start) begin
          ctrl    = CTRL_MDU;
          state_d = MDU_BUSY;
        end else if (branch_redirect) begin
          ctrl     = CTRL_BRANCH;
          redirect = 1'b1;
        end else if (load_use) begin
          ctrl = CTRL_LDUSE;
        end
      end
      MDU_BUSY: begin
        if (freeze) begin
          ctrl = CTRL_FREEZE;
          // A result arriving while frozen is remembered for the release cycle.
          if (mdu_done) begin
            done_pend_d = 1'b1;
          end
        end else if (mdu_done || done_pend_q) begin
          ctrl        = CTRL_RUN;
          done_pend_d = 1'b0;
          state_d     = RUN;
        end else begin
          ctrl = CTRL_MDU;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Watchdog: count consecutive freeze cycles, latch the error at the limit.
  always_comb begin
    wait_d    = '0;
    timeout_d = timeout_q;
    if (freeze) begin
      wait_d = (wait_q == WDOG_LIMIT) ? wait_q : wait_q + WDOG_W'(1);
      if (wait_d == WDOG_LIMIT) begin
        timeout_d = 1'b1;
      end
    end
  end

  // Control-state registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= RUN;
      done_pend_q <= 1'b0;
      wait_q      <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_pend_q <= done_pend_d;
      wait_q      <= wait_d;
      timeout_q   <= timeout_d;
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign ifid_en      = ctrl.ifid_en;
  assign idexe_en     = ctrl.idexe_en;
  assign exemem_en    = ctrl.exemem_en;
  assign memwb_en     = ctrl.memwb_en;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idexe_flush  = ctrl.idexe_flush;
  assign exemem_flush = ctrl.exemem_flush;
  assign mdu_busy     = (state_q == MDU_BUSY);
  assign timeout_err  = timeout_q;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~ctrl.pc_en),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (redirect),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with hand-computed expectations.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        im_stall, dm_stall, load_use, branch_redirect, mdu_start, mdu_done;
  logic        pc_en, ifid_en, idexe_en, exemem_en, memwb_en;
  logic        ifid_flush, idexe_flush, exemem_flush, mdu_busy, timeout_err;
  logic [31:0] stall_cnt, flush_cnt;

  // Small-width counter instance to reach saturation quickly.
  logic        sc_rst, sc_inc;
  logic [3:0]  sc_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .im_stall        (im_stall),
    .dm_stall        (dm_stall),
    .load_use        (load_use),
    .branch_redirect (branch_redirect),
    .mdu_start       (mdu_start),
    .mdu_done        (mdu_done),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .idexe_en        (idexe_en),
    .exemem_en       (exemem_en),
    .memwb_en        (memwb_en),
    .ifid_flush      (ifid_flush),
    .idexe_flush     (idexe_flush),
    .exemem_flush    (exemem_flush),
    .mdu_busy        (mdu_busy),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .timeout_err     (timeout_err)
  );

  sat_counter #(.WIDTH(4)) u_sc (
    .clk   (clk),
    .rst   (sc_rst),
    .inc   (sc_inc),
    .count (sc_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {pc, ifid, idexe, exemem, memwb, ifid_f, idexe_f, exemem_f, busy}
  function automatic logic [31:0] outs();
    return {23'd0, pc_en, ifid_en, idexe_en, exemem_en, memwb_en,
            ifid_flush, idexe_flush, exemem_flush, mdu_busy};
  endfunction

  localparam logic [31:0] O_IDLE     = 32'b11111_000_0;
  localparam logic [31:0] O_IDLE_BSY = 32'b11111_000_1;
  localparam logic [31:0] O_BRANCH   = 32'b11111_110_0;
  localparam logic [31:0] O_LDUSE    = 32'b00111_010_0;
  localparam logic [31:0] O_MDU_RUN  = 32'b00011_001_0;
  localparam logic [31:0] O_MDU_BSY  = 32'b00011_001_1;
  localparam logic [31:0] O_FRZ_RUN  = 32'b00000_000_0;
  localparam logic [31:0] O_FRZ_BSY  = 32'b00000_000_1;

  task automatic drive(input logic im, input logic dm, input logic lu,
                       input logic br, input logic ms, input logic md);
    im_stall = im; dm_stall = dm; load_use = lu;
    branch_redirect = br; mdu_start = ms; mdu_done = md;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs, check combinational outputs mid-cycle, then clock.
  task automatic cycle(input string tag, input logic [5:0] in, input logic [31:0] exp);
    drive(in[5], in[4], in[3], in[2], in[1], in[0]);
    @(negedge clk);
    check(tag, outs(), exp);
    tick();
  endtask

  // Input vector order: {im, dm, lu, br, ms, md}
  initial begin
    rst = 1'b1; sc_rst = 1'b1; sc_inc = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_flush_cnt", flush_cnt, 32'd0);
    check("rst_timeout", {31'd0, timeout_err}, 32'd0);
    for (int i = 0; i < 3; i++) cycle("idle", 6'b000000, O_IDLE);
    check("idle_stall_cnt", stall_cnt, 32'd0);
    check("idle_flush_cnt", flush_cnt, 32'd0);

    // Branch beats load-use.
    cycle("br_lu", 6'b001100, O_BRANCH);
    check("br_lu_flush_cnt", flush_cnt, 32'd1);
    check("br_lu_stall_cnt", stall_cnt, 32'd0);

    // Load-use alone.
    cycle("lu", 6'b001000, O_LDUSE);
    check("lu_stall_cnt", stall_cnt, 32'd1);
    check("lu_flush_cnt", flush_cnt, 32'd1);

    // mdu_start, 4 waiting cycles, mdu_done: five pc_en=0 cycles.
    cycle("mdu_start", 6'b000010, O_MDU_RUN);
    for (int i = 0; i < 4; i++) cycle("mdu_wait", 6'b000000, O_MDU_BSY);
    cycle("mdu_done", 6'b000001, O_IDLE_BSY);
    cycle("mdu_back_run", 6'b000000, O_IDLE);
    check("mdu_stall_cnt", stall_cnt, 32'd6);

    // dm_stall 3 cycles in MDU_BUSY with mdu_done in the second.
    cycle("mdu_start2", 6'b000010, O_MDU_RUN);
    cycle("frz1", 6'b010000, O_FRZ_BSY);
    cycle("frz2_done", 6'b010001, O_FRZ_BSY);
    cycle("frz3", 6'b010000, O_FRZ_BSY);
    cycle("frz_release", 6'b000000, O_IDLE_BSY);
    cycle("frz_run", 6'b000000, O_IDLE);
    check("frz_stall_cnt", stall_cnt, 32'd10);

    // Freeze outranks mdu_start in RUN: no transition.
    cycle("frz_over_ms", 6'b100010, O_FRZ_RUN);
    cycle("frz_over_ms_after", 6'b000000, O_IDLE);

    // mdu_start outranks branch; redirect not counted.
    cycle("ms_over_br", 6'b000110, O_MDU_RUN);
    cycle("ms_over_br_done", 6'b000101, O_IDLE_BSY);
    check("ms_over_br_flush_cnt", flush_cnt, 32'd1);
    check("ms_over_br_stall_cnt", stall_cnt, 32'd12);

    // Reset mid-MDU_BUSY abandons the operation.
    cycle("mdu_start3", 6'b000010, O_MDU_RUN);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cycle("post_rst_idle", 6'b000000, O_IDLE);
    check("post_rst_stall_cnt", stall_cnt, 32'd0);
    check("post_rst_flush_cnt", flush_cnt, 32'd0);

    // Watchdog clears on any unfrozen cycle.
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 200; i++) tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) tick();
    check("wdog_cleared", {31'd0, timeout_err}, 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // im_stall held 260 cycles: error on the 255th consecutive cycle.
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 254; i++) tick();
    check("wdog_254", {31'd0, timeout_err}, 32'd0);
    tick();
    check("wdog_255", {31'd0, timeout_err}, 32'd1);
    for (int i = 0; i < 5; i++) tick();
    check("wdog_stall_cnt", stall_cnt, 32'd260);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    check("wdog_sticky", {31'd0, timeout_err}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wdog_rst", {31'd0, timeout_err}, 32'd0);

    // Saturation of the shared counter, shown on a 4-bit instance.
    sc_rst = 1'b0;
    sc_inc = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    check("sat_14", {28'd0, sc_count}, 32'd14);
    for (int i = 0; i < 6; i++) tick();
    check("sat_hold", {28'd0, sc_count}, 32'd15);
    sc_inc = 1'b0;
    tick();
    check("sat_idle", {28'd0, sc_count}, 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
